// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared constants and occupancy-width helper for reg_pipe
package reg_pipe_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int STAGES_DEF = 2;

    function automatic int occ_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage: one valid/data register pair with load enable and synchronous flush
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              load,
    input  logic              up_valid,
    input  logic [DATA_W-1:0] up_data,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else begin
            valid <= flush ? 1'b0 : load ? up_valid : valid;
            // data only moves with a real beat, and flush leaves it untouched
            if (load && up_valid && !flush)
                data <= up_data;
        end
    end

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: STAGES-deep valid/ready register pipeline with bubble collapse and flush
// Optional occupancy port enabled by REG_PIPE_OCC_EN.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int                DATA_W    = DATA_W_DEF,
    parameter int                STAGES    = STAGES_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [DATA_W-1:0]            out_data,
    input  logic                         out_ready
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [occ_w(STAGES)-1:0]     occ
`endif
);

    logic [STAGES-1:0] v;
    logic [DATA_W-1:0] d [STAGES];
    logic [STAGES:0]   rdy;

    // a stage can load when empty or when the stage below is moving
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--)
            rdy[k] = ~v[k] | rdy[k+1];
    end

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic              uv;
        logic [DATA_W-1:0] ud;
        if (i == 0) begin : g_head
            assign uv = in_valid;
            assign ud = in_data;
        end else begin : g_body
            assign uv = v[i-1];
            assign ud = d[i-1];
        end
        reg_pipe_stage #(
            .DATA_W    (DATA_W),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .reset_n  (reset_n),
            .flush    (flush),
            .load     (rdy[i]),
            .up_valid (uv),
            .up_data  (ud),
            .valid    (v[i]),
            .data     (d[i])
        );
    end

    assign in_ready  = rdy[0] & ~flush;
    assign out_valid = v[STAGES-1] & ~flush;
    assign out_data  = d[STAGES-1];

`ifdef REG_PIPE_OCC_EN
    always_comb begin
        occ = '0;
        for (int k = 0; k < STAGES; k++)
            occ = occ + occ_w(STAGES)'(v[k]);
    end
`endif

endmodule
